// File: rtl/fir_apb_master.sv
// APB initiator for the FIR configuration bus: turns single valid/ready commands
// into APB setup/access transfers and returns one response per transfer.
module fir_apb_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic        pready,
  input  logic [31:0] prdata,
  output logic        busy,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // The counter holds the number of completed wait cycles, so the TIMEOUT-th
  // ACCESS cycle is the one where it equals TIMEOUT-1.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] tmo_cnt;

  // NOTE: every register here, including the captured command fields, is reset
  // so the bus and response outputs are known the instant rst is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      busy      <= 1'b0;
      err_count <= '0;
      tmo_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every output updates from
      // the same pre-edge state, matching the registered-output timing.
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state     <= SETUP;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            psel      <= 1'b1;
            pwrite    <= cmd_write;
            paddr     <= cmd_addr;
            pwdata    <= cmd_write ? cmd_wdata : 32'h0;
            pstrb     <= cmd_write ? cmd_wstrb : 4'h0;
          end
        end

        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
          tmo_cnt <= '0;
        end

        ACCESS: begin
          // pready wins over the limit on the same cycle: that is a normal completion.
          if (pready || tmo_cnt == TMO_LAST) begin
            state     <= RESP;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_error <= ~pready;
            rsp_rdata <= (pready && !pwrite) ? prdata : 32'h0;
            if (!pready && err_count != 16'hFFFF)
              err_count <= err_count + 16'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_apb_master.sv
// Directed bench for fir_apb_master with TIMEOUT=4 and a hand-driven APB completer.
module tb_fir_apb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite, pready;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic        busy;
  logic [15:0] err_count;

  int n_vec  = 0;
  int n_miss = 0;

  fir_apb_master #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, then act as completer: pready rises on ACCESS cycle waits+1.
  // Returns in the first RESP cycle with the observed response.
  task automatic run_xfer(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input int waits, input logic [31:0] rd,
                          output int n_access, output logic [31:0] rdata,
                          output logic err);
    logic bad;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    tick();
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 32'hFFFF_FFFF;
    cmd_wdata = 32'hA5A5_A5A5; cmd_wstrb = 4'h5;
    check({tag, "_setup_psel"},    32'(psel),    32'd1);
    check({tag, "_setup_penable"}, 32'(penable), 32'd0);
    check({tag, "_setup_paddr"},   paddr,        addr);
    check({tag, "_setup_pstrb"},   32'(pstrb),   wr ? 32'(strb) : 32'd0);
    check({tag, "_setup_pwdata"},  pwdata,       wr ? wdata : 32'd0);
    n_access = 0;
    bad = 1'b0;
    for (int i = 0; i < 64 && !rsp_valid; i++) begin
      if (penable) begin
        n_access++;
        if (!psel || paddr !== addr || pwrite !== wr || pstrb !== (wr ? strb : 4'h0))
          bad = 1'b1;
        pready = (n_access > waits);
        prdata = rd;
      end
      tick();
    end
    pready = 1'b0;
    check({tag, "_rsp_within_bound"}, 32'(rsp_valid), 32'd1);
    check({tag, "_access_stable"},    32'(bad),       32'd0);
    rdata = rsp_rdata;
    err   = rsp_error;
  endtask

  int          na;
  logic [31:0] rd;
  logic        er;
  logic [31:0] held;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b1; pready = 1'b0; prdata = '0;
    tick(); tick();
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_psel",      32'(psel),      32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    rst = 1'b0;
    tick();

    // Zero-wait write
    run_xfer("wr0", 1'b1, 32'h08, 32'h0000_1234, 4'hF, 0, 32'h5555_AAAA, na, rd, er);
    check("wr0_access_cycles", 32'(na), 32'd1);
    check("wr0_rdata", rd, 32'h0);
    check("wr0_error", 32'(er), 32'd0);
    tick();
    check("wr0_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check("wr0_idle_busy",      32'(busy),      32'd0);

    // Read with 3 wait states
    run_xfer("rd3", 1'b0, 32'h20, 32'h1111_2222, 4'hC, 3, 32'hCAFE_F00D, na, rd, er);
    check("rd3_access_cycles", 32'(na), 32'd4);
    check("rd3_rdata", rd, 32'hCAFE_F00D);
    check("rd3_error", 32'(er), 32'd0);
    tick();

    // Timeout: completer never ready
    check("tmo_err_count_before", 32'(err_count), 32'd0);
    run_xfer("tmo", 1'b0, 32'h40, 32'h0, 4'h0, 1000, 32'hDEAD_BEEF, na, rd, er);
    check("tmo_access_cycles", 32'(na), 32'd4);
    check("tmo_rdata", rd, 32'h0);
    check("tmo_error", 32'(er), 32'd1);
    check("tmo_err_count_after", 32'(err_count), 32'd1);
    tick();

    // Write after the timeout completes normally
    run_xfer("wr1", 1'b1, 32'h0C, 32'h8765_4321, 4'h3, 1, 32'h0, na, rd, er);
    check("wr1_access_cycles", 32'(na), 32'd2);
    check("wr1_error", 32'(er), 32'd0);
    tick();

    // pready on exactly the TIMEOUT-th ACCESS cycle
    run_xfer("bnd", 1'b0, 32'h10, 32'h0, 4'h0, 3, 32'h0BAD_CAFE, na, rd, er);
    check("bnd_access_cycles", 32'(na), 32'd4);
    check("bnd_error", 32'(er), 32'd0);
    check("bnd_rdata", rd, 32'h0BAD_CAFE);
    check("bnd_err_count", 32'(err_count), 32'd1);
    tick();

    // Response backpressure, with an ignored command presented meanwhile
    rsp_ready = 1'b0;
    run_xfer("bp", 1'b0, 32'h24, 32'h0, 4'h0, 0, 32'h1357_9BDF, na, rd, er);
    held = rsp_rdata;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h99;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", rsp_rdata, held);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_psel",      32'(psel),      32'd0);
    end
    check("bp_rdata_value", held, 32'h1357_9BDF);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("bp_release_cmd_ready", 32'(cmd_ready), 32'd1);
    check("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);

    // Reset in the middle of ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rst_pre_penable", 32'(penable), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_psel",      32'(psel),      32'd0);
    check("rst_penable",   32'(penable),   32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_err_count", 32'(err_count), 32'd0);
    tick();
    check("rst_held_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    tick();

    run_xfer("rdr", 1'b0, 32'h34, 32'h0, 4'h0, 2, 32'h2468_ACE0, na, rd, er);
    check("rdr_access_cycles", 32'(na), 32'd3);
    check("rdr_rdata", rd, 32'h2468_ACE0);
    check("rdr_error", 32'(er), 32'd0);
    tick();
    check("rdr_idle_cmd_ready", 32'(cmd_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
